// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the dual-port memory slave.
package riscv_mem_pkg;

    localparam int unsigned WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_WAIT = 2'd1,
        RD_RESP = 2'd2
    } rd_state_e;

    typedef enum logic {
        WR_IDLE = 1'b0,
        WR_WAIT = 1'b1
    } wr_state_e;

    localparam logic [3:0] BE_B0 = 4'b0001;
    localparam logic [3:0] BE_B1 = 4'b0010;
    localparam logic [3:0] BE_B2 = 4'b0100;
    localparam logic [3:0] BE_B3 = 4'b1000;
    localparam logic [3:0] BE_H0 = BE_B1 | BE_B0;
    localparam logic [3:0] BE_H1 = BE_B3 | BE_B2;
    localparam logic [3:0] BE_W  = BE_H1 | BE_H0;

    // Expand a 4-bit byte enable into a 32-bit lane mask.
    function automatic logic [31:0] be_mask(input logic [3:0] be);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) begin
            m[8*b +: 8] = {8{be[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/dualport_bus.sv
// Independent read and write request/grant channels between master and memory.
interface dualport_bus;
    logic        rd_req;
    logic [3:0]  rd_be;
    logic [31:0] rd_addr;
    logic        rd_gnt;
    logic [31:0] rd_data;
    logic        wr_req;
    logic [3:0]  wr_be;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_gnt;

    modport slave (
        input  rd_req, rd_be, rd_addr, wr_req, wr_be, wr_addr, wr_data,
        output rd_gnt, rd_data, wr_gnt
    );

    modport master (
        output rd_req, rd_be, rd_addr, wr_req, wr_be, wr_addr, wr_data,
        input  rd_gnt, rd_data, wr_gnt
    );
endinterface

// File: rtl/riscv_be_ram.sv
// 32-bit single-clock RAM with per-byte write enables and a registered read port.
module riscv_be_ram #(
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic [3:0]            we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [31:0]           wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [31:0]           rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // Byte-lane write; storage deliberately has no reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // Read register samples old contents on a same-edge write (read-first).
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/riscv_mem_slave.sv
// Memory slave with independent read/write FSMs, wait states and byte masking.
module riscv_mem_slave
    import riscv_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned RD_WAIT    = 0,
    parameter int unsigned WR_WAIT    = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    dualport_bus.slave mem_slave
);

    localparam int unsigned CW = WAIT_CNT_W;

    rd_state_e             rd_state_q, rd_state_d;
    logic [CW-1:0]         rd_cnt_q, rd_cnt_d;
    logic [3:0]            rd_be_q, rd_be_d;
    logic                  rd_capture_c;
    logic                  rd_gnt;

    wr_state_e             wr_state_q, wr_state_d;
    logic [CW-1:0]         wr_cnt_q, wr_cnt_d;
    logic                  wr_fire_c;
    logic                  wr_commit_c;

    logic [ADDR_WIDTH-1:0] rd_idx;
    logic [ADDR_WIDTH-1:0] wr_idx;
    logic [31:0]           ram_rdata;

    assign rd_idx = mem_slave.rd_addr[ADDR_WIDTH+1:2];
    assign wr_idx = mem_slave.wr_addr[ADDR_WIDTH+1:2];

    // Byte offset and bits above the array alias silently.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_slave.rd_addr[31:ADDR_WIDTH+2], mem_slave.rd_addr[1:0],
                                mem_slave.wr_addr[31:ADDR_WIDTH+2], mem_slave.wr_addr[1:0]};

    // Read FSM next state: wait countdown, capture on entry to RD_RESP.
    always_comb begin
        rd_state_d   = rd_state_q;
        rd_cnt_d     = rd_cnt_q;
        rd_be_d      = rd_be_q;
        rd_capture_c = 1'b0;
        unique case (rd_state_q)
            RD_IDLE: begin
                if (mem_slave.rd_req) begin
                    if (RD_WAIT == 0) begin
                        rd_state_d   = RD_RESP;
                        rd_capture_c = 1'b1;
                    end else begin
                        rd_state_d = riscv_mem_pkg::RD_WAIT;
                        rd_cnt_d   = CW'(RD_WAIT);
                    end
                end
            end
            riscv_mem_pkg::RD_WAIT: begin
                if (!mem_slave.rd_req) begin
                    rd_state_d = RD_IDLE;
                    rd_cnt_d   = '0;
                end else if (rd_cnt_q <= CW'(1)) begin
                    rd_state_d   = RD_RESP;
                    rd_capture_c = 1'b1;
                    rd_cnt_d     = '0;
                end else begin
                    rd_cnt_d = CW'(rd_cnt_q - CW'(1));
                end
            end
            RD_RESP: begin
                rd_state_d = RD_IDLE;
            end
            default: begin
                rd_state_d = RD_IDLE;
                rd_cnt_d   = '0;
            end
        endcase
        if (rd_capture_c) begin
            rd_be_d = mem_slave.rd_be;
        end
    end

    // Read FSM state, counter and captured byte enables.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_q <= RD_IDLE;
            rd_cnt_q   <= '0;
            rd_be_q    <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_be_q    <= rd_be_d;
        end
    end

    // Write FSM next state: zero-wait grants combinationally, else counts down.
    always_comb begin
        wr_state_d = wr_state_q;
        wr_cnt_d   = wr_cnt_q;
        wr_fire_c  = 1'b0;
        if (WR_WAIT == 0) begin
            wr_state_d = WR_IDLE;
            wr_cnt_d   = '0;
            wr_fire_c  = mem_slave.wr_req;
        end else begin
            unique case (wr_state_q)
                WR_IDLE: begin
                    if (mem_slave.wr_req) begin
                        wr_state_d = riscv_mem_pkg::WR_WAIT;
                        wr_cnt_d   = CW'(WR_WAIT);
                    end
                end
                riscv_mem_pkg::WR_WAIT: begin
                    if (!mem_slave.wr_req) begin
                        wr_state_d = WR_IDLE;
                        wr_cnt_d   = '0;
                    end else if (wr_cnt_q <= CW'(1)) begin
                        wr_fire_c  = 1'b1;
                        wr_state_d = WR_IDLE;
                        wr_cnt_d   = '0;
                    end else begin
                        wr_cnt_d = CW'(wr_cnt_q - CW'(1));
                    end
                end
                default: begin
                    wr_state_d = WR_IDLE;
                    wr_cnt_d   = '0;
                end
            endcase
        end
    end

    // Reset suppresses a grant (and so the commit) even on the zero-wait path.
    assign wr_commit_c = wr_fire_c & rst_n;

    // Write FSM state and counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q <= WR_IDLE;
            wr_cnt_q   <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_cnt_q   <= wr_cnt_d;
        end
    end

    riscv_be_ram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk  (clk),
        .we   ({4{wr_commit_c}} & mem_slave.wr_be),
        .waddr(wr_idx),
        .wdata(mem_slave.wr_data),
        .re   (rd_capture_c),
        .raddr(rd_idx),
        .rdata(ram_rdata)
    );

    assign rd_gnt            = (rd_state_q == RD_RESP);
    assign mem_slave.rd_gnt  = rd_gnt;
    assign mem_slave.rd_data = rd_gnt ? (ram_rdata & be_mask(rd_be_q)) : 32'h0;
    assign mem_slave.wr_gnt  = wr_commit_c;

endmodule

// File: tb/tb_riscv_mem_slave.sv
// Directed + randomized check of three riscv_mem_slave configurations.
module tb_riscv_mem_slave;

    localparam int unsigned AW = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        rd_req  [3];
    logic [3:0]  rd_be   [3];
    logic [31:0] rd_addr [3];
    logic        wr_req  [3];
    logic [3:0]  wr_be   [3];
    logic [31:0] wr_addr [3];
    logic [31:0] wr_data [3];
    logic        rd_gnt_o  [3];
    logic [31:0] rd_data_o [3];
    logic        wr_gnt_o  [3];

    dualport_bus bus0 ();
    dualport_bus bus1 ();
    dualport_bus bus2 ();

    assign bus0.rd_req = rd_req[0]; assign bus0.rd_be = rd_be[0]; assign bus0.rd_addr = rd_addr[0];
    assign bus0.wr_req = wr_req[0]; assign bus0.wr_be = wr_be[0]; assign bus0.wr_addr = wr_addr[0];
    assign bus0.wr_data = wr_data[0];
    assign rd_gnt_o[0] = bus0.rd_gnt; assign rd_data_o[0] = bus0.rd_data; assign wr_gnt_o[0] = bus0.wr_gnt;
    assign bus1.rd_req = rd_req[1]; assign bus1.rd_be = rd_be[1]; assign bus1.rd_addr = rd_addr[1];
    assign bus1.wr_req = wr_req[1]; assign bus1.wr_be = wr_be[1]; assign bus1.wr_addr = wr_addr[1];
    assign bus1.wr_data = wr_data[1];
    assign rd_gnt_o[1] = bus1.rd_gnt; assign rd_data_o[1] = bus1.rd_data; assign wr_gnt_o[1] = bus1.wr_gnt;
    assign bus2.rd_req = rd_req[2]; assign bus2.rd_be = rd_be[2]; assign bus2.rd_addr = rd_addr[2];
    assign bus2.wr_req = wr_req[2]; assign bus2.wr_be = wr_be[2]; assign bus2.wr_addr = wr_addr[2];
    assign bus2.wr_data = wr_data[2];
    assign rd_gnt_o[2] = bus2.rd_gnt; assign rd_data_o[2] = bus2.rd_data; assign wr_gnt_o[2] = bus2.wr_gnt;

    riscv_mem_slave #(.ADDR_WIDTH(AW), .RD_WAIT(0), .WR_WAIT(0))
        dut0 (.clk(clk), .rst_n(rst_n), .mem_slave(bus0));
    riscv_mem_slave #(.ADDR_WIDTH(AW), .RD_WAIT(3), .WR_WAIT(2))
        dut1 (.clk(clk), .rst_n(rst_n), .mem_slave(bus1));
    riscv_mem_slave #(.ADDR_WIDTH(AW), .RD_WAIT(5), .WR_WAIT(0))
        dut2 (.clk(clk), .rst_n(rst_n), .mem_slave(bus2));

    // Reference memory: one word array per instance, indexed by word address.
    logic [31:0] mdl [3][4096];

    int ncmp  = 0;
    int nfail = 0;

    function automatic int rdw(input int k);
        return (k == 0) ? 0 : (k == 1) ? 3 : 5;
    endfunction

    function automatic int wrw(input int k);
        return (k == 1) ? 2 : 0;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(a[AW+1:2]);
    endfunction

    // Expected read: stored word with disabled byte lanes returned as zero.
    function automatic logic [31:0] mdl_read(input int k, input logic [31:0] a, input logic [3:0] be);
        logic [31:0] w;
        logic [31:0] r;
        w = mdl[k][widx(a)];
        r = 32'h0;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = w[8*b +: 8];
        return r;
    endfunction

    task automatic mdl_write(input int k, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        for (int b = 0; b < 4; b++) if (be[b]) mdl[k][widx(a)][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one write; the call starts between a rising edge and the next falling edge.
    task automatic do_write(input int k, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] be, input string tag);
        int  n;
        bit  got;
        n = 0; got = 0;
        wr_req[k] = 1'b1; wr_addr[k] = a; wr_data[k] = d; wr_be[k] = be;
        while (!got && n < 40) begin
            @(negedge clk);
            if (wr_gnt_o[k] === 1'b1) got = 1;
            else begin
                @(posedge clk); #1; n++;
            end
        end
        chk({tag, "_wlat"}, 32'(n), 32'(wrw(k)));
        @(posedge clk);
        if (got) mdl_write(k, a, d, be);
        #1;
        wr_req[k] = 1'b0;
    endtask

    // Issue one read, checking latency, returned data and zero data while stalled.
    task automatic do_read(input int k, input logic [31:0] a, input logic [3:0] be,
                           input logic [31:0] exp, input string tag);
        int n;
        bit got;
        n = 0; got = 0;
        rd_req[k] = 1'b1; rd_addr[k] = a; rd_be[k] = be;
        while (!got && n < 40) begin
            @(negedge clk);
            if (rd_gnt_o[k] === 1'b1) got = 1;
            else begin
                if (n == 0) chk({tag, "_stall_data"}, rd_data_o[k], 32'h0);
                @(posedge clk); #1; n++;
            end
        end
        chk({tag, "_rlat"}, 32'(n), 32'(rdw(k) + 1));
        chk({tag, "_rdata"}, rd_data_o[k], exp);
        @(posedge clk); #1;
        rd_req[k] = 1'b0;
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        int          gcount;
        for (int k = 0; k < 3; k++) begin
            rd_req[k] = 0; rd_be[k] = 0; rd_addr[k] = 0;
            wr_req[k] = 0; wr_be[k] = 0; wr_addr[k] = 0; wr_data[k] = 0;
        end

        // Reset: all outputs low.
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_rd_gnt%0d", k), 32'(rd_gnt_o[k]), 32'h0);
            chk($sformatf("rst_rd_data%0d", k), rd_data_o[k], 32'h0);
            chk($sformatf("rst_wr_gnt%0d", k), 32'(wr_gnt_o[k]), 32'h0);
        end
        rst_n = 1'b1;
        tick();

        // Word write then read, zero waits.
        do_write(0, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, "w_word");
        do_read(0, 32'h0000_0010, 4'b1111, 32'hDEAD_BEEF, "r_word");

        // Byte-lane write and masked reads.
        do_write(0, 32'h0000_0010, 32'h00AA_0000, 4'b0100, "w_byte");
        do_read(0, 32'h0000_0010, 4'b1111, 32'hDEAA_BEEF, "r_full");
        do_read(0, 32'h0000_0010, 4'b0011, 32'h0000_BEEF, "r_half");

        // Aliasing and empty write.
        do_write(0, 32'h0000_4010, 32'h1234_5678, 4'b1111, "w_alias");
        do_read(0, 32'h0000_0010, 4'b1111, 32'h1234_5678, "r_alias");
        do_write(0, 32'h0000_0010, 32'hFFFF_FFFF, 4'b0000, "w_empty");
        do_read(0, 32'h0000_0013, 4'b1111, 32'h1234_5678, "r_empty");

        // Collision: read capture and write commit on the same edge.
        do_write(0, 32'h0000_0020, 32'h1111_1111, 4'b1111, "w_col0");
        rd_req[0] = 1; rd_addr[0] = 32'h20; rd_be[0] = 4'hF;
        wr_req[0] = 1; wr_addr[0] = 32'h20; wr_data[0] = 32'h2222_2222; wr_be[0] = 4'hF;
        @(negedge clk);
        chk("col_wr_gnt", 32'(wr_gnt_o[0]), 32'h1);
        chk("col_rd_gnt_early", 32'(rd_gnt_o[0]), 32'h0);
        @(posedge clk);
        mdl_write(0, 32'h20, 32'h2222_2222, 4'hF);
        #1; wr_req[0] = 0;
        @(negedge clk);
        chk("col_rd_gnt", 32'(rd_gnt_o[0]), 32'h1);
        chk("col_rd_data", rd_data_o[0], 32'h1111_1111);
        tick(); rd_req[0] = 0;
        do_read(0, 32'h0000_0020, 4'b1111, 32'h2222_2222, "r_col_after");

        // Back-to-back writes grant every cycle.
        wr_req[0] = 1; wr_be[0] = 4'hF;
        for (int i = 0; i < 4; i++) begin
            wr_addr[0] = 32'h40 + 32'(4 * i); wr_data[0] = $urandom();
            @(negedge clk);
            chk($sformatf("b2b_wr_gnt%0d", i), 32'(wr_gnt_o[0]), 32'h1);
            @(posedge clk);
            mdl_write(0, wr_addr[0], wr_data[0], 4'hF);
            #1;
        end
        wr_req[0] = 0;
        for (int i = 0; i < 4; i++) begin
            a = 32'h40 + 32'(4 * i);
            do_read(0, a, 4'hF, mdl_read(0, a, 4'hF), $sformatf("b2b_rd%0d", i));
        end

        // Back-to-back reads grant every second cycle.
        rd_req[0] = 1; rd_addr[0] = 32'h44; rd_be[0] = 4'hF;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("b2b_rd_gnt%0d", i), 32'(rd_gnt_o[0]), 32'(i % 2));
            if (i % 2 == 1) chk($sformatf("b2b_rd_data%0d", i), rd_data_o[0], mdl_read(0, 32'h44, 4'hF));
            tick();
        end
        rd_req[0] = 0;
        tick();

        // Wait states on instance 1.
        do_write(1, 32'h0000_0030, 32'hCAFE_F00D, 4'b1111, "ws_w");
        do_read(1, 32'h0000_0030, 4'b1111, 32'hCAFE_F00D, "ws_r");

        // Abandoned read and write: no grant, no memory change.
        rd_req[1] = 1; rd_addr[1] = 32'h30; rd_be[1] = 4'hF;
        wr_req[1] = 1; wr_addr[1] = 32'h30; wr_data[1] = 32'h0BAD_0BAD; wr_be[1] = 4'hF;
        tick();
        wr_req[1] = 0;
        tick();
        rd_req[1] = 0;
        gcount = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            gcount += int'(rd_gnt_o[1]) + int'(wr_gnt_o[1]);
            tick();
        end
        chk("abort_no_gnt", 32'(gcount), 32'h0);
        do_read(1, 32'h0000_0030, 4'b1111, 32'hCAFE_F00D, "abort_r");

        // Randomized traffic against the reference memory.
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 16; j++) begin
                a = {14'($urandom()), 12'(64 + j), 2'($urandom())};
                do_write(k, a, $urandom(), 4'hF, $sformatf("rnd_init%0d_%0d", k, j));
            end
            for (int j = 0; j < 24; j++) begin
                a  = {14'($urandom()), 12'(64 + $urandom_range(0, 15)), 2'($urandom())};
                be = 4'($urandom_range(0, 15));
                d  = $urandom();
                if ($urandom_range(0, 1) == 1) do_write(k, a, d, be, $sformatf("rnd_w%0d_%0d", k, j));
                else do_read(k, a, be, mdl_read(k, a, be), $sformatf("rnd_r%0d_%0d", k, j));
            end
        end

        // Reset two cycles into a long read.
        rd_req[2] = 1; rd_addr[2] = 32'h104; rd_be[2] = 4'hF;
        tick(); tick();
        #2;
        rst_n = 0; wr_req[2] = 1; wr_addr[2] = 32'h104; wr_data[2] = 32'hFFFF_0000; wr_be[2] = 4'hF;
        #1;
        chk("rstmid_rd_gnt", 32'(rd_gnt_o[2]), 32'h0);
        chk("rstmid_rd_data", rd_data_o[2], 32'h0);
        chk("rstmid_wr_gnt", 32'(wr_gnt_o[2]), 32'h0);
        gcount = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            gcount += int'(rd_gnt_o[2]) + int'(wr_gnt_o[2]);
        end
        chk("rstmid_no_gnt", 32'(gcount), 32'h0);
        rd_req[2] = 0; wr_req[2] = 0;
        tick(); #2;
        rst_n = 1;
        do_read(2, 32'h104, 4'hF, mdl_read(2, 32'h104, 4'hF), "rst_fresh_r");
        do_read(0, 32'h10, 4'hF, 32'h1234_5678, "rst_mem_kept");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
